// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, opcode constants and mux-select codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'd0,
      AluOpSub   = 2'd1,
      AluOpFunct = 2'd2
   } aluop_t;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARd1   = 2'b10;

   localparam logic [1:0] SrcBRd2  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ImmI = 2'b00;
   localparam logic [1:0] ImmS = 2'b01;
   localparam logic [1:0] ImmB = 2'b10;
   localparam logic [1:0] ImmJ = 2'b11;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   // States whose exit edge completes an instruction.
   function automatic logic is_retire(input state_t s);
      return (s == StMemWb) || (s == StMemWrite) || (s == StAluWb) || (s == StBeq);
   endfunction

   function automatic logic op_supported(input logic [6:0] o);
      return (o == OpLoad) || (o == OpStore) || (o == OpRtype) || (o == OpItype) ||
             (o == OpBranch) || (o == OpJal);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode from the FSM's aluop class and the
// instruction's funct fields.
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       op_b5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = AluAdd;
      unique case (aluop)
         AluOpAdd: alu_control = AluAdd;
         AluOpSub: alu_control = AluSub;
         AluOpFunct: begin
            unique case (funct3)
               // Only R-type distinguishes sub; addi ignores instr[30].
               3'b000:  alu_control = (op_b5 & funct7b5) ? AluSub : AluAdd;
               3'b010:  alu_control = AluSlt;
               3'b110:  alu_control = AluOr;
               3'b111:  alu_control = AluAnd;
               default: alu_control = AluAdd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the shared-ALU multi-cycle RV32I datapath, with a
// retired-instruction counter and an illegal-opcode pulse.
module multi_cycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       imm_src,
   output logic [2:0]       alu_control,
   output logic             reg_write,
   output logic             illegal,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   aluop_t           aluop;
   logic             pc_update, branch;
   logic             ir_write_m, mem_write_m, reg_write_m, illegal_m;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            if (op == OpLoad || op == OpStore) state_d = StMemAdr;
            else if (op == OpRtype)            state_d = StExecR;
            else if (op == OpItype)            state_d = StExecI;
            else if (op == OpJal)              state_d = StJal;
            else if (op == OpBranch)           state_d = StBeq;
            else                               state_d = StFetch;
         end
         StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBeq:      state_d = StFetch;
         StJal:      state_d = StAluWb;
         default:    state_d = StFetch;
      endcase
   end

   always_comb begin
      adr_src     = 1'b0;
      ir_write_m  = 1'b0;
      mem_write_m = 1'b0;
      reg_write_m = 1'b0;
      illegal_m   = 1'b0;
      result_src  = ResAluOut;
      alu_src_a   = SrcAPc;
      alu_src_b   = SrcBRd2;
      aluop       = AluOpAdd;
      pc_update   = 1'b0;
      branch      = 1'b0;
      unique case (state_q)
         StFetch: begin
            ir_write_m = 1'b1;
            alu_src_b  = SrcBFour;
            result_src = ResAluResult;
            pc_update  = 1'b1;
         end
         StDecode: begin
            // Precompute the branch target while the opcode is decoded.
            alu_src_a = SrcAOldPc;
            alu_src_b = SrcBImm;
            illegal_m = ~op_supported(op);
         end
         StMemAdr: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBImm;
         end
         StMemRead: adr_src = 1'b1;
         StMemWb: begin
            result_src  = ResData;
            reg_write_m = 1'b1;
         end
         StMemWrite: begin
            adr_src     = 1'b1;
            mem_write_m = 1'b1;
         end
         StExecR: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBRd2;
            aluop     = AluOpFunct;
         end
         StExecI: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBImm;
            aluop     = AluOpFunct;
         end
         StAluWb: reg_write_m = 1'b1;
         StBeq: begin
            alu_src_a = SrcARd1;
            alu_src_b = SrcBRd2;
            aluop     = AluOpSub;
            branch    = 1'b1;
         end
         StJal: begin
            alu_src_a = SrcAOldPc;
            alu_src_b = SrcBFour;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case (op)
         OpLoad, OpItype: imm_src = ImmI;
         OpStore:         imm_src = ImmS;
         OpBranch:        imm_src = ImmB;
         OpJal:           imm_src = ImmJ;
         default:         imm_src = ImmI;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop       (aluop),
      .funct3      (funct3),
      .op_b5       (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q <= '0;
      end else if (is_retire(state_q)) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

   // Enables are held low for the whole reset assertion, not just after the edge.
   assign pc_write  = ~reset & (pc_update | (branch & zero));
   assign ir_write  = ~reset & ir_write_m;
   assign mem_write = ~reset & mem_write_m;
   assign reg_write = ~reset & reg_write_m;
   assign illegal   = ~reset & illegal_m;
   assign state_o   = state_q;
   assign instret   = instret_q;

endmodule
